// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl: read-miss refill controller for a direct-mapped cache.
//
// Accepts a CPU read, looks it up in the cache and returns the word on a hit.
// On a miss it fetches the whole line from backing memory one word per
// mem_ack, writes every word into the cache and returns the requested word.
//
// Optional feature: define CACHE_STATS_EN to add saturating 32-bit hit/miss
// counters (hit_count, miss_count).
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   cpu_req/cpu_addr           CPU read request (held until cpu_ack)
//   cpu_ack/cpu_rdata/cpu_hit  one-cycle response; data and hit flag hold
//   cache_addr                 lookup address (always the latched address)
//   cache_hit/cache_rdata      combinational cache lookup result
//   fill_we/fill_addr/fill_data/fill_last  refill write port to the cache
//   mem_req/mem_addr           backing-memory word read request
//   mem_ack/mem_rdata          backing-memory data return
//   busy                       controller not idle
//   hit_count/miss_count       (CACHE_STATS_EN only) response statistics
module cache_refill_ctrl #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_hit,
  output logic [ADDR_W-1:0] cache_addr,
  input  logic              cache_hit,
  input  logic [DATA_W-1:0] cache_rdata,
  output logic              fill_we,
  output logic [ADDR_W-1:0] fill_addr,
  output logic [DATA_W-1:0] fill_data,
  output logic              fill_last,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int unsigned OffW = $clog2(LINE_WORDS);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StLookup  = 2'd1;
  localparam logic [1:0] StRefill  = 2'd2;
  localparam logic [1:0] StRespond = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [OffW-1:0]   beat_q;
  logic [DATA_W-1:0] word_q;
  logic [DATA_W-1:0] rdata_q;
  logic              hit_q;

  logic            in_refill;
  logic            beat_ack;
  logic            last_beat;
  logic            off_match;
  logic [OffW-1:0] word_off;

  assign word_off  = addr_q[OffW+1:2];
  assign in_refill = (state_q == StRefill);
  // Gated by rst_n so a reset cycle never writes a stray beat into the cache.
  assign beat_ack  = in_refill && mem_ack && rst_n;
  assign last_beat = (beat_q == OffW'(LINE_WORDS - 1));
  assign off_match = (beat_q == word_off);

  assign cache_addr = addr_q;
  assign mem_req    = in_refill;
  // Line base with the beat index substituted as the word offset.
  assign mem_addr   = in_refill ? {addr_q[ADDR_W-1:OffW+2], beat_q, 2'b00} : '0;

  assign fill_we   = beat_ack;
  assign fill_addr = beat_ack ? mem_addr : '0;
  assign fill_data = beat_ack ? mem_rdata : '0;
  assign fill_last = beat_ack && last_beat;

  assign cpu_ack   = (state_q == StRespond);
  assign cpu_rdata = rdata_q;
  assign cpu_hit   = hit_q;
  assign busy      = (state_q != StIdle);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:    if (cpu_req) state_d = StLookup;
      StLookup:  state_d = cache_hit ? StRespond : StRefill;
      StRefill:  if (mem_ack && last_beat) state_d = StRespond;
      StRespond: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // The response registers only change on the way into StRespond, so
  // cpu_rdata/cpu_hit hold the previous answer throughout a later request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      beat_q  <= '0;
      word_q  <= '0;
      rdata_q <= '0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        StIdle: begin
          if (cpu_req) addr_q <= cpu_addr;
        end
        StLookup: begin
          beat_q <= '0;
          if (cache_hit) begin
            rdata_q <= cache_rdata;
            hit_q   <= 1'b1;
          end
        end
        StRefill: begin
          if (mem_ack) begin
            beat_q <= beat_q + OffW'(1);
            if (off_match) word_q <= mem_rdata;
            if (last_beat) begin
              // The requested word may itself be the final beat.
              rdata_q <= off_match ? mem_rdata : word_q;
              hit_q   <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (cpu_ack) begin
      if (hit_q) begin
        if (hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_q <= hit_cnt_q + 32'd1;
      end else begin
        if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb_cache_refill_ctrl: directed self-checking bench for cache_refill_ctrl.
// Covers reset, a hit, a fast miss, a slow-memory miss, reset in mid-refill
// and recovery. Statistics checks are compiled in with CACHE_STATS_EN.
module tb_cache_refill_ctrl;

  logic        clk;
  logic        rst_n;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic        cpu_ack;
  logic [31:0] cpu_rdata;
  logic        cpu_hit;
  logic [31:0] cache_addr;
  logic        cache_hit;
  logic [31:0] cache_rdata;
  logic        fill_we;
  logic [31:0] fill_addr;
  logic [31:0] fill_data;
  logic        fill_last;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        busy;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  cache_refill_ctrl #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .LINE_WORDS(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_req    (cpu_req),
    .cpu_addr   (cpu_addr),
    .cpu_ack    (cpu_ack),
    .cpu_rdata  (cpu_rdata),
    .cpu_hit    (cpu_hit),
    .cache_addr (cache_addr),
    .cache_hit  (cache_hit),
    .cache_rdata(cache_rdata),
    .fill_we    (fill_we),
    .fill_addr  (fill_addr),
    .fill_data  (fill_data),
    .fill_last  (fill_last),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .busy       (busy)
`ifdef CACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Per-transaction observations filled in by run_txn.
  logic [31:0] fills[$];
  logic        acked;
  int          ack_cyc;
  logic [31:0] got_rdata;
  logic        got_hit;
  int          last_cnt;
  logic [31:0] last_addr;
  int          bad_fill;
  int          unstable;
  int          req_cycles;
  logic        post_busy;
  logic        post_ack;
  logic [31:0] post_rdata;

  // Issue one read and run a memory model that acks each address `delay`
  // cycles after it appears. Outside refill, mem_ack is driven high with junk
  // data to show it is ignored. cpu_addr is scrambled once latched.
  task automatic run_txn(input logic [31:0] addr, input logic hit, input logic [31:0] hdata,
                         input int delay);
    int          wcnt;
    logic        prev_req;
    logic        prev_ack;
    logic [31:0] prev_addr;
    wcnt = 0; prev_req = 1'b0; prev_ack = 1'b0; prev_addr = '0;
    fills.delete();
    acked = 1'b0; ack_cyc = 0; got_rdata = '0; got_hit = 1'b0;
    last_cnt = 0; last_addr = '0; bad_fill = 0; unstable = 0; req_cycles = 0;
    cpu_req = 1'b1; cpu_addr = addr; cache_hit = hit; cache_rdata = hdata;
    for (int cyc = 1; cyc <= 200 && !acked; cyc++) begin
      @(negedge clk);
      if (cyc == 1) cpu_addr = 32'hFFFF_FFF0;
      if (mem_req) begin
        if (wcnt == delay) begin
          mem_ack = 1'b1; mem_rdata = mem_addr; wcnt = 0;
        end else begin
          mem_ack = 1'b0; wcnt++;
        end
      end else begin
        mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0; wcnt = 0;
      end
      #1;
      if (mem_req) req_cycles++;
      if (mem_req && prev_req && !prev_ack && mem_addr !== prev_addr) unstable++;
      if (fill_we !== (mem_req && mem_ack)) bad_fill++;
      if (fill_we && fill_data !== mem_rdata) bad_fill++;
      if (fill_we) fills.push_back(fill_addr);
      if (fill_last) begin
        last_cnt++; last_addr = fill_addr;
      end
      prev_req = mem_req; prev_ack = mem_ack; prev_addr = mem_addr;
      if (cpu_ack) begin
        acked = 1'b1; ack_cyc = cyc; got_rdata = cpu_rdata; got_hit = cpu_hit;
        cpu_req = 1'b0;
      end
    end
    check("txn_ack_seen", 64'(acked), 64'd1);
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    post_busy = busy; post_ack = cpu_ack; post_rdata = cpu_rdata;
  endtask

  task automatic check_fills(input string tag, input logic [31:0] base);
    check({tag, "_fill_cnt"}, 64'(fills.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      check({tag, "_fill_addr"}, (i < fills.size()) ? 64'(fills[i]) : 64'hDEAD,
            64'(base + 32'(4 * i)));
    end
    check({tag, "_last_cnt"}, 64'(last_cnt), 64'd1);
    check({tag, "_last_addr"}, 64'(last_addr), 64'(base + 32'hC));
    check({tag, "_bad_fill"}, 64'(bad_fill), 64'd0);
  endtask

  int nfill;
  int lastseen;

  initial begin
    rst_n = 1'b0;
    cpu_req = $urandom; cpu_addr = $urandom; cache_hit = $urandom; cache_rdata = $urandom;
    mem_ack = $urandom; mem_rdata = $urandom;
    @(negedge clk);
    cpu_req = $urandom; cpu_addr = $urandom; cache_hit = $urandom; cache_rdata = $urandom;
    mem_ack = $urandom; mem_rdata = $urandom;
    @(negedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_cpu_ack", 64'(cpu_ack), 64'd0);
    check("rst_cpu_hit", 64'(cpu_hit), 64'd0);
    check("rst_cpu_rdata", 64'(cpu_rdata), 64'd0);
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_fill_we", 64'(fill_we), 64'd0);
    check("rst_fill_last", 64'(fill_last), 64'd0);
    check("rst_fill_addr", 64'(fill_addr), 64'd0);
    check("rst_fill_data", 64'(fill_data), 64'd0);
    check("rst_cache_addr", 64'(cache_addr), 64'd0);
    rst_n = 1'b1;
    cpu_req = 1'b0; cpu_addr = '0; cache_hit = 1'b0; cache_rdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;

    // Hit at 0x40: ack in cycle 2, no memory traffic.
    run_txn(32'h40, 1'b1, 32'hDEAD_BEEF, 0);
    check("hit_ack_cycle", 64'(ack_cyc), 64'd2);
    check("hit_flag", 64'(got_hit), 64'd1);
    check("hit_rdata", 64'(got_rdata), 64'hDEAD_BEEF);
    check("hit_mem_req_cycles", 64'(req_cycles), 64'd0);
    check("hit_fill_cnt", 64'(fills.size()), 64'd0);
    check("hit_bad_fill", 64'(bad_fill), 64'd0);
    check("hit_post_busy", 64'(post_busy), 64'd0);
    check("hit_post_ack", 64'(post_ack), 64'd0);
    check("hit_post_rdata", 64'(post_rdata), 64'hDEAD_BEEF);

    // Miss at 0x1238, memory acks every cycle: LOOKUP, 4 beats, RESPOND.
    run_txn(32'h0000_1238, 1'b0, 32'h1111_1111, 0);
    check_fills("miss", 32'h1230);
    check("miss_ack_cycle", 64'(ack_cyc), 64'd6);
    check("miss_flag", 64'(got_hit), 64'd0);
    check("miss_rdata", 64'(got_rdata), 64'h0000_1238);
    check("miss_post_rdata", 64'(post_rdata), 64'h0000_1238);

    // Slow memory at 0x2004: each beat takes 4 cycles, ack in cycle 2+16.
    run_txn(32'h0000_2004, 1'b0, 32'h2222_2222, 3);
    check_fills("slow", 32'h2000);
    check("slow_req_cycles", 64'(req_cycles), 64'd16);
    check("slow_unstable", 64'(unstable), 64'd0);
    check("slow_ack_cycle", 64'(ack_cyc), 64'd18);
    check("slow_flag", 64'(got_hit), 64'd0);
    check("slow_rdata", 64'(got_rdata), 64'h0000_2004);

    // Reset after two refill beats abandons the line.
    cpu_req = 1'b1; cpu_addr = 32'h0000_1238; cache_hit = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h55AA_55AA;
    nfill = 0; lastseen = 0;
    for (int cyc = 1; cyc <= 20 && nfill < 2; cyc++) begin
      @(negedge clk);
      cpu_req = 1'b0;
      #1;
      if (fill_we) nfill++;
      if (fill_last) lastseen++;
    end
    check("rstmid_beats", 64'(nfill), 64'd2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstmid_fill_we_in_rst", 64'(fill_we), 64'd0);
    if (fill_last) lastseen++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rstmid_busy", 64'(busy), 64'd0);
    check("rstmid_mem_req", 64'(mem_req), 64'd0);
    check("rstmid_fill_we", 64'(fill_we), 64'd0);
    if (fill_last) lastseen++;
    check("rstmid_no_last", 64'(lastseen), 64'd0);
    mem_ack = 1'b0;

    // Recovery: a fresh miss at 0x80 completes normally.
    run_txn(32'h0000_0080, 1'b0, 32'h3333_3333, 0);
    check_fills("after", 32'h0080);
    check("after_ack_cycle", 64'(ack_cyc), 64'd6);
    check("after_flag", 64'(got_hit), 64'd0);
    check("after_rdata", 64'(got_rdata), 64'h0000_0080);

    // A second hit with different data replaces the held response.
    run_txn(32'h0000_0084, 1'b1, 32'h1234_5678, 0);
    check("hit2_flag", 64'(got_hit), 64'd1);
    check("hit2_rdata", 64'(got_rdata), 64'h1234_5678);

`ifdef CACHE_STATS_EN
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("stats_rst_hit", 64'(hit_count), 64'd0);
    check("stats_rst_miss", 64'(miss_count), 64'd0);
    for (int i = 0; i < 3; i++) run_txn(32'h100 + 32'(4 * i), 1'b1, 32'hA5A5_0000, 0);
    for (int i = 0; i < 2; i++) run_txn(32'h200 + 32'(4 * i), 1'b0, 32'h0, 0);
    check("stats_hit_count", 64'(hit_count), 64'd3);
    check("stats_miss_count", 64'(miss_count), 64'd2);
    dut.hit_cnt_q = 32'hFFFF_FFFF;
    run_txn(32'h300, 1'b1, 32'h0BAD_CAFE, 0);
    check("stats_hit_sat", 64'(hit_count), 64'hFFFF_FFFF);
    check("stats_miss_hold", 64'(miss_count), 64'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_refill_ctrl.md
CACHE_REFILL_CTRL -- requirements
Module: cache_refill_ctrl

Interface
REQ-001 SHALL have these parameters (name, default, meaning):
- ADDR_W, 32, byte address width.
- DATA_W, 32, word width.
- LINE_WORDS, 4, words per cache line; power of 2, at least 2.

REQ-002 SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, the only clock; all logic on its rising edge.
- rst_n, in, 1, synchronous active-low reset.
- cpu_req, in, 1, read request; held by requester until cpu_ack.
- cpu_addr, in, ADDR_W, requested byte address; bits [1:0] ignored.
- cpu_ack, out, 1, one-cycle pulse; cpu_rdata/cpu_hit valid.
- cpu_rdata, out, DATA_W, returned word; holds until next cpu_ack.
- cpu_hit, out, 1, 1 = served without refill; holds with cpu_rdata.
- cache_addr, out, ADDR_W, lookup address driven to the direct-mapped cache.
- cache_hit, in, 1, combinational hit for cache_addr.
- cache_rdata, in, DATA_W, combinational data for cache_addr.
- fill_we, out, 1, write one refill word into the cache.
- fill_addr, out, ADDR_W, byte address of the refill word.
- fill_data, out, DATA_W, refill word.
- fill_last, out, 1, marks the final word of a line; cache sets tag/valid only on this.
- mem_req, out, 1, backing-memory read request.
- mem_addr, out, ADDR_W, word-aligned memory address.
- mem_ack, in, 1, memory data valid this cycle.
- mem_rdata, in, DATA_W, memory read data.
- busy, out, 1, high whenever state is not IDLE.

Function
REQ-003 SHALL implement FSM states IDLE, LOOKUP, REFILL, RESPOND.
REQ-004 IDLE: when cpu_req=1 at an edge, SHALL latch cpu_addr into addr_q and enter LOOKUP; cpu_req is ignored in other states.
REQ-005 cache_addr SHALL equal addr_q at all times.
REQ-006 LOOKUP:
- cache_hit=1: SHALL capture cache_rdata, set hit flag 1 and enter RESPOND.
- Otherwise: SHALL enter REFILL with beat counter 0.
REQ-007 RESPOND SHALL assert cpu_ack for exactly one cycle, drive the captured word and flag, then return to IDLE.
REQ-008 Hit latency: request sampled at edge 0 gives cpu_ack high during cycle 2.
REQ-009 REFILL behaviour:
- mem_req held at 1.
- mem_addr = line base (addr_q with low log2(LINE_WORDS)+2 bits cleared) + 4*beat.
- mem_addr stable until mem_ack.
REQ-010 In REFILL, fill_we SHALL equal mem_ack (combinational), with fill_addr=mem_addr and fill_data=mem_rdata; fill_we is 0 in every other state.
REQ-011 On each mem_ack the beat counter SHALL increment; when beat equals the word offset of addr_q, mem_rdata SHALL be captured as the response word.
REQ-012 On mem_ack at beat LINE_WORDS-1, fill_last SHALL be 1 that cycle, hit flag SHALL be 0, and the next state is RESPOND.
REQ-013 mem_ack outside REFILL SHALL be ignored.
REQ-014 Address changes on cpu_addr after latching SHALL have no effect.

Reset
REQ-015 When rst_n=0 at an edge, the block SHALL reset as follows:
- State returns to IDLE and the beat counter to 0.
- cpu_ack, cpu_hit, cpu_rdata, mem_req, fill_we, fill_last and busy are 0 from the next cycle.
- addr_q is 0.
REQ-016 Reset during REFILL SHALL abandon the line with no further fill_we and no fill_last, so the partial line stays invalid.

Configuration
REQ-017 With macro CACHE_STATS_EN defined:
- SHALL add outputs hit_count and miss_count, 32 bits each.
- Each increments in the RESPOND cycle according to the hit flag.
- Each saturates at 0xFFFFFFFF and resets to 0.
REQ-018 Without CACHE_STATS_EN, those ports and counters SHALL be absent and behaviour is otherwise identical.

Verification
REQ-019 Reset: rst_n=0 for 2 cycles with random inputs -> all outputs 0, busy 0.
REQ-020 Hit: cache_hit=1, cache_rdata=0xDEADBEEF, cpu_req with addr 0x40 at edge 0 -> cpu_ack in cycle 2, cpu_hit=1, cpu_rdata=0xDEADBEEF, mem_req never 1.
REQ-021 Miss: cache_hit=0, addr 0x00001238, mem_ack every cycle with mem_rdata=mem_addr -> the bench SHALL check:
- mem_addr sequence 0x1230, 0x1234, 0x1238, 0x123C.
- 4 fill_we pulses, fill_last only with 0x123C.
- cpu_rdata=0x00001238, cpu_hit=0.
REQ-022 Slow memory: mem_ack given 3 cycles after each address -> mem_req and mem_addr stable while waiting, no fill_we without mem_ack, cpu_ack after the 4th ack.
REQ-023 Reset after 2 refill beats -> next cycle busy=0, mem_req=0, fill_last never seen; a following request to 0x80 completes normally.
REQ-024 CACHE_STATS_EN: 3 hits then 2 misses -> hit_count=3, miss_count=2; a preloaded value of 0xFFFFFFFF stays at 0xFFFFFFFF after a further hit.
